// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the 5-stage MIPS pipeline. It sits beside the ID-stage decoder.
//   It detects load-use and jr/jalr register hazards. It flushes on taken branches, which
//   resolve in EX, and on jumps, which resolve in ID. It also sequences the multi-cycle
//   mult/div unit and holds mfhi/mflo and back-to-back mult/div until HI/LO are valid.
//
//   Parameters
//     MD_LATENCY  mult/div busy cycles (>=1)
//     CNT_W       performance counter width
//
//   Optional feature macro: HAZARD_PERF_EN
//     Defined:   stall_cycles and flush_cycles count stall and flush cycles, saturating.
//     Undefined: both counters are tied to 0 and no counter flops exist.
//
//   Ports
//     clk, rst_n                          clock, async active-low reset
//     id_rs, id_rt, id_use_rs, id_use_rt  ID source registers and their use flags
//     id_jr, id_jump                      jr/jalr in ID, any jump in ID
//     id_md_start, id_md_read             mult/div start, mfhi/mflo in ID
//     ex_mem_read, ex_reg_write, ex_wr_reg  EX load, EX register write, EX destination
//     mem_mem_read, mem_wr_reg            MEM load and its destination
//     ex_branch_taken                     taken branch in EX
//     pc_write, ifid_write                PC and IF/ID enables
//     ifid_flush, idex_flush              bubble insertion
//     md_busy, md_done                    mult/div in progress, last busy cycle
//     stall_cycles, flush_cycles          performance counters
//
//   state | meaning
//   ------+--------------------------------------------
//   IDLE  | no mult/div in flight, HI/LO valid
//   BUSY  | mult/div running, cnt counts down to 0 (md_done)
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_jr,
  input  logic             id_jump,
  input  logic             id_md_start,
  input  logic             id_md_read,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_wr_reg,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_wr_reg,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  localparam int MD_CW = $clog2(MD_LATENCY + 1);
  localparam logic [MD_CW-1:0] MD_LOAD = MD_CW'(MD_LATENCY - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

  md_state_t        state, state_nxt;
  logic [MD_CW-1:0] cnt, cnt_nxt;

  logic lu_hz, jr_hz, md_hz;

  // Register 0 is hardwired to zero, so it never creates a dependence.
  always_comb begin
    lu_hz = ex_mem_read && (ex_wr_reg != 5'd0) &&
            ((id_use_rs && (ex_wr_reg == id_rs)) || (id_use_rt && (ex_wr_reg == id_rt)));
    jr_hz = id_jr && (((ex_reg_write && (ex_wr_reg != 5'd0)) && (ex_wr_reg == id_rs)) ||
                      ((mem_mem_read && (mem_wr_reg != 5'd0)) && (mem_wr_reg == id_rs)));
    md_hz = md_busy && (id_md_start || id_md_read);
  end

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (md_hz || lu_hz || jr_hz) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A start in BUSY is never accepted here. md_hz stalls it until the FSM is back in IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    md_busy   = (state == BUSY);
    md_done   = (state == BUSY) && (cnt == '0);
    case (state)
      IDLE: begin
        if (id_md_start && !ex_branch_taken && !lu_hz && !jr_hz) begin
          state_nxt = BUSY;
          cnt_nxt   = MD_LOAD;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - MD_CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
      if ((ifid_flush || idex_flush) && (flush_q != {CNT_W{1'b1}}))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule
